// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew data-hazard detection plus the mult/div busy timer.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic       D_is_md,
   input  logic [4:0] E_wa,
   input  logic [1:0] E_Tnew,
   input  logic [4:0] M_wa,
   input  logic [1:0] M_Tnew,
   input  logic       E_md_start,
   input  logic       E_md_op,
   output logic       F_en,
   output logic       FD_en,
   output logic       DE_flush,
   output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt
`endif
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CLOG_W     = $clog2(MAX_CYCLES + 1);
   localparam int unsigned CNT_W      = (CLOG_W > 4) ? CLOG_W : 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t        state;
   md_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_load;
   logic             rst_done;
   logic             md_start_ok;
   logic             stall_rs;
   logic             stall_rt;
   logic             md_stall;
   logic             stall;

   // A start coinciding with the reset-release edge is dropped.
   assign md_start_ok = E_md_start & rst_done;
   assign cnt_load    = E_md_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rst_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rst_done <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (md_start_ok) begin
               state_nxt = BUSY;
               cnt_nxt   = cnt_load;
            end
         end
         BUSY: begin
            if (md_start_ok) begin
               cnt_nxt = cnt_load;
            end else if (cnt == CNT_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Tuse of 3 can never be below a 2-bit Tnew, so unused operands never stall.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (D_rs != 5'd0) begin
         stall_rs = ((E_wa == D_rs) && (D_Tuse_rs < E_Tnew)) ||
                    ((M_wa == D_rs) && (D_Tuse_rs < M_Tnew));
      end
      if (D_rt != 5'd0) begin
         stall_rt = ((E_wa == D_rt) && (D_Tuse_rt < E_Tnew)) ||
                    ((M_wa == D_rt) && (D_Tuse_rt < M_Tnew));
      end
   end

   always_comb begin
      md_busy  = (state == BUSY);
      md_stall = reset & D_is_md & (md_busy | E_md_start);
      stall    = reset & (stall_rs | stall_rt | md_stall);
      F_en     = ~stall;
      FD_en    = ~stall;
      DE_flush = stall;
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt    <= '0;
         md_stall_cnt <= '0;
      end else begin
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (md_stall) begin
            md_stall_cnt <= md_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized scoreboard bench for hazard_stall_ctrl against a cycle-level reference model.
module tb_hazard_stall_ctrl;
   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] D_rs, D_rt, E_wa, M_wa;
   logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
   logic       D_is_md, E_md_start, E_md_op;
   logic       F_en, FD_en, DE_flush, md_busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
      .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md),
      .E_wa(E_wa), .E_Tnew(E_Tnew), .M_wa(M_wa), .M_Tnew(M_Tnew),
      .E_md_start(E_md_start), .E_md_op(E_md_op),
      .F_en(F_en), .FD_en(FD_en), .DE_flush(DE_flush), .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
   );

   typedef struct {
      logic        f_en;
      logic        fd_en;
      logic        de_flush;
      logic        md_busy;
      logic [31:0] sc;
      logic [31:0] mc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_left = 0;
   bit   prev_rst = 1'b0;
   logic [31:0] stall_tally = 0;
   logic [31:0] md_tally = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic bit hazard(int r, int tuse, int ewa, int etn, int mwa, int mtn);
      if (r == 0) return 1'b0;
      return ((ewa == r) && (tuse < etn)) || ((mwa == r) && (tuse < mtn));
   endfunction

   // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("F_en", 32'(F_en), 32'(e.f_en));
            chk("FD_en", 32'(FD_en), 32'(e.fd_en));
            chk("DE_flush", 32'(DE_flush), 32'(e.de_flush));
            chk("md_busy", 32'(md_busy), 32'(e.md_busy));
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, e.sc);
            chk("md_stall_cnt", md_stall_cnt, e.mc);
`endif
         end
      end
   end

   // One pipeline cycle: drive, predict, push, then advance the model across the edge.
   task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt, input logic is_md,
                       input logic [4:0] ewa, input logic [1:0] etn,
                       input logic [4:0] mwa, input logic [1:0] mtn,
                       input logic st, input logic op);
      exp_t e;
      bit   md_st, stl;
      if (!prev_rst) st = 1'b0;
      reset = rst; D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
      D_is_md = is_md; E_wa = ewa; E_Tnew = etn; M_wa = mwa; M_Tnew = mtn;
      E_md_start = st; E_md_op = op;
      if (!rst) begin
         busy_left   = 0;
         stall_tally = 0;
         md_tally    = 0;
      end
      md_st = rst && is_md && ((busy_left > 0) || st);
      stl   = rst && (md_st ||
                      hazard(int'(rs), int'(tu_rs), int'(ewa), int'(etn), int'(mwa), int'(mtn)) ||
                      hazard(int'(rt), int'(tu_rt), int'(ewa), int'(etn), int'(mwa), int'(mtn)));
      e.f_en = !stl; e.fd_en = !stl; e.de_flush = stl; e.md_busy = (busy_left > 0);
      e.sc = stall_tally; e.mc = md_tally;
      sb.push_back(e);
      @(posedge clk);
      if (rst) begin
         if (stl) stall_tally = stall_tally + 1;
         if (md_st) md_tally = md_tally + 1;
         if (st) busy_left = op ? DIV_N : MULT_N;
         else if (busy_left > 0) busy_left--;
      end
      prev_rst = rst;
      #1;
   endtask

   task automatic idle(input logic is_md, input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 3, 3, is_md, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [4:0] rs, rt, ewa, mwa;
      logic [1:0] tur, tut, etn, mtn;
      logic       rst, md, st, op;
      reset = 1'b0; D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_is_md = 0;
      E_wa = 0; E_Tnew = 0; M_wa = 0; M_Tnew = 0; E_md_start = 0; E_md_op = 0;
      @(posedge clk); #1;
      step(0, 8, 0, 0, 3, 1, 8, 2, 0, 0, 1, 0);
      step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 2);
      // Data hazards on rs via E and rt via M.
      step(1, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 0);
      step(1, 0, 9, 3, 1, 0, 0, 0, 9, 1, 0, 0);
      step(1, 0, 9, 3, 0, 0, 0, 0, 9, 1, 0, 0);
      step(1, 0, 9, 3, 0, 0, 0, 0, 9, 3, 0, 0);
      // Mult with an HI/LO instruction held in D.
      step(1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
      idle(1, 7);
      // Div interrupted by reset at busy cycle 4.
      step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
      idle(1, 3);
      step(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      idle(1, 4);
      // Div restarted at busy cycle 3.
      step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
      idle(0, 2);
      step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
      idle(1, 12);
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         rs  = 5'($urandom_range(0, 3)); rt  = 5'($urandom_range(0, 3));
         ewa = 5'($urandom_range(0, 3)); mwa = 5'($urandom_range(0, 3));
         tur = 2'($urandom_range(0, 3)); tut = 2'($urandom_range(0, 3));
         etn = 2'($urandom_range(0, 3)); mtn = 2'($urandom_range(0, 3));
         md  = ($urandom_range(0, 2) == 0);
         st  = ($urandom_range(0, 9) == 0);
         op  = 1'($urandom_range(0, 1));
         step(rst, rs, rt, tur, tut, md, ewa, etn, mwa, mtn, st, op);
      end
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
